// File: rtl/tx_burst_sequencer_pkg.sv
// Shared types and address helpers for the transmit burst sequencer.
// Button addresses are 1-based, so the real RAM base is one below them, wrapping at the buffer depth.
package tx_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    CAP  = 2'd2,
    SEND = 2'd3
  } state_t;

  typedef enum logic {
    SEL_UP = 1'b0,
    SEL_DN = 1'b1
  } grant_sel_t;

  localparam int MEM_RD_LATENCY = 1;

  // Single-step wrap: value is expected to lie below 2*depth.
  function automatic int unsigned addr_wrap(input int unsigned value, input int unsigned depth);
    return (value >= depth) ? value - depth : value;
  endfunction

  function automatic int unsigned base_from_btn(input logic [20:0] addr21, input int unsigned depth);
    int unsigned m;
    m = 32'(addr21) % depth;
    return (m == 0) ? depth - 1 : m - 1;
  endfunction

endpackage

// File: rtl/tx_burst_sequencer_if.sv
// Bundle of requester, buffer-RAM and transmitter signals around the burst sequencer.
// The master side is the sequencer; the slave side is its environment.
interface tx_burst_sequencer_if #(
  parameter int DATAWIDTH = 8,
  parameter int MEMAW     = 4
);

  logic                 req_up;
  logic [20:0]          addr_up;
  logic                 req_dn;
  logic [20:0]          addr_dn;
  logic                 mem_en;
  logic [MEMAW-1:0]     mem_addr;
  logic [DATAWIDTH-1:0] mem_rdata;
  logic [DATAWIDTH-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic                 busy;
  logic                 done;
  logic                 dropped;

  modport master (
    input  req_up, addr_up, req_dn, addr_dn, mem_rdata, tx_ready,
    output mem_en, mem_addr, tx_data, tx_valid, busy, done, dropped
  );

  modport slave (
    output req_up, addr_up, req_dn, addr_dn, mem_rdata, tx_ready,
    input  mem_en, mem_addr, tx_data, tx_valid, busy, done, dropped
  );

endinterface

// File: rtl/tx_burst_sequencer_arb.sv
// Fixed-priority two-way request arbiter: up beats down, and nothing is granted unless idle.
// Any request that does not win a grant is reported as a drop.
module req_arbiter2
  import tx_seq_pkg::*;
(
  input  logic       idle,
  input  logic       req_up,
  input  logic       req_dn,
  output grant_sel_t grant_sel,
  output logic       grant_valid,
  output logic       drop
);

  logic any_req;

  always_comb begin
    any_req     = req_up || req_dn;
    grant_sel   = req_up ? SEL_UP : SEL_DN;
    grant_valid = idle && any_req;
    drop        = any_req && (!idle || (req_up && req_dn));
  end

endmodule

// File: rtl/tx_burst_sequencer.sv
// Reads BURST consecutive words from the message buffer per accepted button request and
// hands each one to the UART transmitter over valid/ready; every output is registered.
module tx_burst_sequencer
  import tx_seq_pkg::*;
#(
  parameter int DATAWIDTH = 8,
  parameter int DATADEPTH = 16,
  parameter int BURST     = 4,
  parameter int MEMAW     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  tx_burst_sequencer_if.master bus
);

  localparam int               CNT_W = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(BURST - 1);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 mem_en_q, mem_en_d;
  logic [MEMAW-1:0]     mem_addr_q, mem_addr_d;
  logic [DATAWIDTH-1:0] tx_data_q, tx_data_d;
  logic                 tx_valid_q, tx_valid_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 dropped_q, dropped_d;

  grant_sel_t           grant_sel;
  logic                 grant_valid;
  logic                 grant_drop;
  logic                 arb_idle;
  logic [MEMAW-1:0]     base_up, base_dn, addr_inc;

  // The done cycle still counts as busy for arbitration, so a request there is dropped.
  assign arb_idle = (state_q == IDLE) && !done_q;

  req_arbiter2 u_arb (
    .idle        (arb_idle),
    .req_up      (bus.req_up),
    .req_dn      (bus.req_dn),
    .grant_sel   (grant_sel),
    .grant_valid (grant_valid),
    .drop        (grant_drop)
  );

  assign base_up  = MEMAW'(base_from_btn(bus.addr_up, DATADEPTH));
  assign base_dn  = MEMAW'(base_from_btn(bus.addr_dn, DATADEPTH));
  assign addr_inc = MEMAW'(addr_wrap(32'(mem_addr_q) + 32'd1, DATADEPTH));

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    mem_en_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    dropped_d  = grant_drop;

    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          state_d    = RD;
          mem_addr_d = (grant_sel == SEL_UP) ? base_up : base_dn;
          mem_en_d   = 1'b1;
          busy_d     = 1'b1;
          count_d    = '0;
        end
      end
      RD: begin
        state_d = CAP;
      end
      CAP: begin
        tx_data_d  = bus.mem_rdata;
        tx_valid_d = 1'b1;
        state_d    = SEND;
      end
      SEND: begin
        if (tx_valid_q && bus.tx_ready) begin
          tx_valid_d = 1'b0;
          if (count_q == LAST) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            count_d    = count_q + 1'b1;
            mem_addr_d = addr_inc;
            mem_en_d   = 1'b1;
            state_d    = RD;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      count_q    <= '0;
      mem_en_q   <= 1'b0;
      mem_addr_q <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dropped_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      mem_en_q   <= mem_en_d;
      mem_addr_q <= mem_addr_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      dropped_q  <= dropped_d;
    end
  end

  assign bus.mem_en   = mem_en_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_valid = tx_valid_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.dropped  = dropped_q;

endmodule

// File: doc/tx_burst_sequencer.md
Name: tx_burst_sequencer

Overview:
- Sequences multi-word transmit bursts out of the message buffer RAM to the UART transmitter.
- Arbitrates between two button-controller requesters: "up" (primary) and "down" (secondary). Each requester supplies a one-shot operation pulse plus a 21-bit address.
- For each accepted request: reads BURST consecutive words from synchronous RAM (1-cycle read latency), then hands each word to the transmitter over a valid/ready handshake.
- Sits between the push-button controllers, the buffer BRAM and uart_tx.

Parameters:
- DATAWIDTH, 8: RAM word width and tx_data width.
- DATADEPTH, 16: number of RAM entries; all addresses wrap modulo DATADEPTH.
- BURST, 4: words sent per accepted request; legal range 1..DATADEPTH.
- MEMAW, 4: mem_addr width; must satisfy 2**MEMAW >= DATADEPTH.

Ports:
- clk  in  1  main clock; single clock domain.
- rst  in  1  asynchronous, active-high reset.
- req_up  in  1  operation pulse from the up-button controller.
- addr_up  in  21  up address; real base address = addr_up - 1.
- req_dn  in  1  operation pulse from the down-button controller.
- addr_dn  in  21  down address; real base address = addr_dn - 1.
- mem_en  out  1  RAM read enable.
- mem_addr  out  MEMAW  RAM read address.
- mem_rdata  in  DATAWIDTH  RAM read data; valid during the cycle after mem_en.
- tx_data  out  DATAWIDTH  word to the transmitter.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  transmitter accepts the word this cycle.
- busy  out  1  high from acceptance until the last word is handed off.
- done  out  1  one-cycle pulse when the last word of a burst transfers.
- dropped  out  1  one-cycle pulse when a request is rejected.

Behaviour:
- Reset (async, immediate):
  - state=IDLE; mem_en=0, mem_addr=0, tx_data=0, tx_valid=0, busy=0, done=0, dropped=0; word counter=0.
  - A burst in progress is abandoned: no further mem_en or tx_valid is issued.
- All outputs are registered.
- Base address computation:
  - base = (addr_x mod DATADEPTH) - 1.
  - If addr_x mod DATADEPTH == 0, base = DATADEPTH-1.
  - Only the low bits are used; full 21-bit values >= DATADEPTH are reduced mod DATADEPTH.
- States:
  - IDLE: if req_up, accept up; else if req_dn, accept dn. On accept: state=RD, mem_addr=base, mem_en=1, busy=1, count=0.
  - RD: mem_en drops to 0 at the next edge; state=CAP.
  - CAP: mem_rdata is valid. At the edge, tx_data=mem_rdata, tx_valid=1, state=SEND.
  - SEND: tx_valid and tx_data are held stable until tx_valid&&tx_ready at an edge. On transfer, tx_valid=0, then:
    - if count==BURST-1: state=IDLE, busy=0, done=1 for one cycle;
    - else: count+1, mem_addr=(mem_addr+1) wrapping DATADEPTH-1 -> 0, mem_en=1, state=RD.
- Latency:
  - Accept edge E: mem_en high in cycle E..E+1.
  - tx_valid rises at edge E+2.
  - Minimum per-word period is 3 cycles when tx_ready is tied high.
  - A full burst takes 3*BURST cycles from acceptance to the done pulse.
- Arbitration and drops:
  - req_up and req_dn both high in IDLE: up wins; dropped pulses for dn.
  - Any request while state != IDLE: ignored; dropped pulses for 1 cycle (one pulse per cycle in which any request is high).
  - A request in the same cycle as the done pulse is dropped; IDLE is only re-entered after that edge.
- Requests are single-cycle pulses. A held level in IDLE is accepted once, then dropped repeatedly while busy.
- tx_ready high outside SEND has no effect.

Decomposition:
- Shared package tx_seq_pkg:
  - state enum {IDLE, RD, CAP, SEND};
  - MEM_RD_LATENCY=1;
  - function addr_wrap(value, depth);
  - function base_from_btn(addr21, depth) implementing the "-1 with wrap" rule.
- One natural sub-module: req_arbiter2.
  - Combinational fixed-priority pick between up and dn.
  - Outputs grant_sel, grant_valid and a drop flag, gated by an idle input.

Test Plan:
1. Reset, then req_up pulse with addr_up=1, tx_ready=1, RAM[i]=i+8'hA0 -> mem_addr 0,1,2,3; tx_data A0,A1,A2,A3 each 3 cycles apart; done pulses at cycle 12 after acceptance; busy low afterwards.
2. addr_dn=0 (DATADEPTH=16) -> base 15; reads 15,0,1,2; tx_data RAM[15],RAM[0],RAM[1],RAM[2].
3. req_up and req_dn in the same IDLE cycle (addr_up=5, addr_dn=9) -> burst starts at address 4; dropped=1 for exactly that cycle; no read at address 8.
4. tx_ready held low for 10 cycles during word 2 -> tx_valid and tx_data stable all 10 cycles; no mem_en; resumes with next mem_en one cycle after transfer.
5. req_dn pulse mid-burst, and another on the done cycle -> dropped pulses twice; burst content unchanged; state IDLE afterwards with no new read.
6. rst asserted asynchronously while in SEND -> tx_valid, mem_en, busy drop immediately without a clock edge; after release a new req_up starts a fresh burst with count=0.
